// File: rtl/cond_branch.sv
// Dataflow steer operator: pairs condition tokens with data tokens in FIFO order
// and routes each data token to the true or false output.

module cond_branch_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en_i,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    input  logic         fire_i,
    output logic         head_valid_o,
    output logic [W-1:0] head_data_o,
    output logic         drop_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic nonempty;
    logic pop_mem;
    logic bypass;
    logic push_req;
    logic push;

    always_comb begin
        nonempty     = (cnt_q != '0);
        head_valid_o = nonempty | push_valid_i;
        head_data_o  = nonempty ? mem_q[rd_q] : push_data_i;
        // An incoming token consumed straight through never touches the storage.
        pop_mem      = fire_i & nonempty;
        bypass       = fire_i & ~nonempty;
        push_req     = en_i & push_valid_i & ~bypass;
        push         = push_req & ((cnt_q != FULL_CNT) | pop_mem);
        drop_o       = push_req & ~push;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (pop_mem) rd_d = rd_q + AW'(1);
        if (push)    wr_d = wr_q + AW'(1);
        if (push && !pop_mem)      cnt_d = cnt_q + CW'(1);
        else if (pop_mem && !push) cnt_d = cnt_q - CW'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage is not reset; occupancy decides which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= push_data_i;
    end
endmodule

module cond_branch #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         R_COND,
    input  logic [N-1:0] D_COND,
    input  logic         R_IN,
    input  logic [N-1:0] D_IN,
    output logic         R_T,
    output logic [N-1:0] D_T,
    output logic         R_F,
    output logic [N-1:0] D_F,
    output logic         OVF
);
    logic         c_head_valid;
    logic [0:0]   c_head_bit;
    logic         c_drop;
    logic         d_head_valid;
    logic [N-1:0] d_head_data;
    logic         d_drop;
    logic         fire;
    logic         cond_true;

    logic         r_t_q, r_t_d;
    logic         r_f_q, r_f_d;
    logic [N-1:0] d_t_q, d_t_d;
    logic [N-1:0] d_f_q, d_f_d;
    logic         ovf_q, ovf_d;

    assign fire = EN & c_head_valid & d_head_valid;

    cond_branch_fifo #(.W(1), .DEPTH(DEPTH)) u_cq (
        .CLK          (CLK),
        .RST          (RST),
        .en_i         (EN),
        .push_valid_i (R_COND),
        .push_data_i  (D_COND != '0),
        .fire_i       (fire),
        .head_valid_o (c_head_valid),
        .head_data_o  (c_head_bit),
        .drop_o       (c_drop)
    );

    cond_branch_fifo #(.W(N), .DEPTH(DEPTH)) u_dq (
        .CLK          (CLK),
        .RST          (RST),
        .en_i         (EN),
        .push_valid_i (R_IN),
        .push_data_i  (D_IN),
        .fire_i       (fire),
        .head_valid_o (d_head_valid),
        .head_data_o  (d_head_data),
        .drop_o       (d_drop)
    );

    always_comb begin
        cond_true = c_head_bit[0];
        r_t_d     = fire & cond_true;
        r_f_d     = fire & ~cond_true;
        d_t_d     = r_t_d ? d_head_data : d_t_q;
        d_f_d     = r_f_d ? d_head_data : d_f_q;
        ovf_d     = ovf_q | c_drop | d_drop;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_t_q <= 1'b0;
            r_f_q <= 1'b0;
            d_t_q <= '0;
            d_f_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            r_t_q <= r_t_d;
            r_f_q <= r_f_d;
            d_t_q <= d_t_d;
            d_f_q <= d_f_d;
            ovf_q <= ovf_d;
        end
    end

    assign R_T = r_t_q;
    assign R_F = r_f_q;
    assign D_T = d_t_q;
    assign D_F = d_f_q;
    assign OVF = ovf_q;
endmodule

// File: tb/tb_cond_branch.sv
// Directed bench for cond_branch: a vector table for steady-state routing plus
// hand-written sequences for overflow, full pop/push and asynchronous reset.

module tb_cond_branch;
    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic         R_COND;
    logic [N-1:0] D_COND;
    logic         R_IN;
    logic [N-1:0] D_IN;
    logic         R_T;
    logic [N-1:0] D_T;
    logic         R_F;
    logic [N-1:0] D_F;
    logic         OVF;

    int n_cmp  = 0;
    int n_fail = 0;

    cond_branch #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .R_COND (R_COND),
        .D_COND (D_COND),
        .R_IN   (R_IN),
        .D_IN   (D_IN),
        .R_T    (R_T),
        .D_T    (D_T),
        .R_F    (R_F),
        .D_F    (D_F),
        .OVF    (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         en;
        logic         rc;
        logic [N-1:0] dc;
        logic         ri;
        logic [N-1:0] di;
        logic         rt;
        logic [N-1:0] dt;
        logic         rf;
        logic [N-1:0] df;
        logic         ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic rc, input logic [N-1:0] dc,
                        input logic ri, input logic [N-1:0] di);
        EN = en; R_COND = rc; D_COND = dc; R_IN = ri; D_IN = di;
        @(posedge CLK);
        #1;
        R_COND = 1'b0; R_IN = 1'b0;
    endtask

    task automatic do_reset();
        EN = 1'b1; R_COND = 1'b0; D_COND = '0; R_IN = 1'b0; D_IN = '0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic rt, input logic [N-1:0] dt,
                              input logic rf, input logic [N-1:0] df, input logic ovf);
        check({tag, " R_T"}, 32'(R_T), 32'(rt));
        check({tag, " D_T"}, 32'(D_T), 32'(dt));
        check({tag, " R_F"}, 32'(R_F), 32'(rf));
        check({tag, " D_F"}, 32'(D_F), 32'(df));
        check({tag, " OVF"}, 32'(OVF), 32'(ovf));
    endtask

    initial begin
        // Simultaneous pair, idle hold, skewed arrival, EN gating, high-bit-only condition.
        vecs[0]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h00AB, 1'b1, 16'h00AB, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h00AB, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h00AB, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h00AB, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 16'h00AB, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h00AB, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h00AB, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h00AB, 1'b1, 16'h0001, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0001, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0003, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0, 16'h0003, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'h0077, 1'b0, 16'h0002, 1'b0, 16'h0003, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0078, 1'b0, 16'h0002, 1'b0, 16'h0003, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'h0079, 1'b0, 16'h0002, 1'b0, 16'h0003, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0, 16'h0003, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 16'h8000, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'h0003, 1'b0};

        // Reset takes effect before any clock edge.
        RST = 1'b1; EN = 1'b0; R_COND = 1'b0; D_COND = '0; R_IN = 1'b0; D_IN = '0;
        #1;
        expect_out("reset", 1'b0, '0, 1'b0, '0, 1'b0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].en, vecs[i].rc, vecs[i].dc, vecs[i].ri, vecs[i].di);
            expect_out($sformatf("vec%0d", i), vecs[i].rt, vecs[i].dt, vecs[i].rf, vecs[i].df, vecs[i].ovf);
        end

        // Overflow: five conditions into a four-deep queue, then four data tokens.
        do_reset();
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0000, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0002, 1'b0, '0);
        check("ovf before drop", 32'(OVF), 32'd0);
        step(1'b1, 1'b1, 16'h0000, 1'b0, '0);
        check("ovf after drop", 32'(OVF), 32'd1);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0010);
        expect_out("ovf d0", 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0011);
        expect_out("ovf d1", 1'b0, 16'h0010, 1'b1, 16'h0011, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0012);
        expect_out("ovf d2", 1'b1, 16'h0012, 1'b0, 16'h0011, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0013);
        expect_out("ovf d3", 1'b1, 16'h0013, 1'b0, 16'h0011, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0014);
        expect_out("ovf d4 none", 1'b0, 16'h0013, 1'b0, 16'h0011, 1'b1);

        // Full condition queue with simultaneous pop and push.
        do_reset();
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0000, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0000, 1'b1, 16'h0021);
        expect_out("full pp", 1'b1, 16'h0021, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0022);
        expect_out("full d1", 1'b1, 16'h0022, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0023);
        expect_out("full d2", 1'b0, 16'h0022, 1'b1, 16'h0023, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0024);
        expect_out("full d3", 1'b1, 16'h0024, 1'b0, 16'h0023, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0025);
        expect_out("full d4", 1'b0, 16'h0024, 1'b1, 16'h0025, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0026);
        expect_out("full empty", 1'b0, 16'h0024, 1'b0, 16'h0025, 1'b0);

        // Asynchronous reset mid-stream with two conditions still buffered.
        do_reset();
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b1, 16'h0031);
        expect_out("arst pulse", 1'b1, 16'h0031, 1'b0, 16'h0000, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        expect_out("arst now", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        step(1'b1, 1'b0, '0, 1'b1, 16'h0032);
        expect_out("arst lost", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cond_branch.md
# cond_branch

Dataflow steer operator: the consumer end of the condition token stream that the comparison operators produce. It pairs each condition token with a data token and routes the data to a true output or a false output. Condition and data tokens may arrive on different cycles, and the R/D protocol has no backpressure, so each input is buffered in a small FIFO. It sits in the datapath graph directly downstream of comparators (BNE, BEQ, …) and upstream of the operators on the taken/not-taken paths.

## Interface
Parameters:
- N, 16, data and condition token width
- DEPTH, 4, entries per input FIFO; power of two, ≥2

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset; asynchronous, active-high
- EN  input  1  operator enable
- R_COND  input  1  condition token valid
- D_COND  input  N  condition value; any nonzero value = true
- R_IN  input  1  data token valid
- D_IN  input  N  data value
- R_T  output  1  true-path token valid, registered
- D_T  output  N  true-path data, registered
- R_F  output  1  false-path token valid, registered
- D_F  output  N  false-path data, registered
- OVF  output  1  sticky overflow flag, registered

## Operation
- Condition FIFO (CQ) stores 1 bit per entry: the value of (D_COND != 0). Data FIFO (DQ) stores N bits. Each FIFO keeps a read pointer, a write pointer and an occupancy count (0..DEPTH).
- Effective head of CQ:
  - the CQ head entry if CQ is non-empty;
  - otherwise the incoming token, if R_COND=1;
  - otherwise none.
  - DQ effective head is defined the same way using R_IN/D_IN.
- Fire condition: EN=1 and both effective heads exist.
- On fire:
  - consume both heads; a bypassed incoming token is not written to its FIFO.
  - if the condition bit = 1: R_T←1, D_T←data, R_F←0.
  - if the condition bit = 0: R_F←1, D_F←data, R_T←0.
- No fire: R_T←0, R_F←0; D_T and D_F hold their previous values.
- Push, per FIFO, when EN=1:
  - an incoming token that was not consumed by bypass is written at the write pointer.
  - it is accepted if occupancy < DEPTH, or if the FIFO pops in the same cycle (full plus simultaneous pop plus push gives occupancy unchanged).
  - otherwise the token is dropped and OVF←1.
- Pointers wrap modulo DEPTH. Occupancy changes by +1 on push only, −1 on pop only, 0 on both or neither.
- EN=0:
  - R_COND and R_IN are ignored; tokens are discarded with no OVF effect.
  - no pops occur and FIFO contents are held.
  - R_T←0, R_F←0; D_T, D_F and OVF hold.
- OVF is sticky and clears only on RST.
- Ordering: tokens are paired strictly first-in-first-out on each input. The k-th accepted condition always pairs with the k-th accepted data token.

## Timing
- Reset (asynchronous, takes effect immediately, no clock needed):
  - R_T=0, R_F=0, D_T=0, D_F=0, OVF=0.
  - both FIFOs empty, all pointers 0.
- Latency:
  - both tokens arriving in the same cycle with both FIFOs empty: output valid on the next edge (1 cycle).
  - otherwise the output appears on the edge at which the later of the two tokens is presented (or becomes FIFO head).
- Throughput: one routed token per cycle maximum. R_T and R_F are never both 1.
- Output valid is a 1-cycle pulse per token. Back-to-back fires produce consecutive pulses.
- Reset asserted mid-operation: all buffered tokens are lost and outputs clear immediately. The first edge after RST deasserts behaves as if starting from empty.

## Test plan
- Simultaneous pair: after reset, one cycle with R_COND=1, D_COND=1, R_IN=1, D_IN=0x00AB → next edge R_T=1, D_T=0x00AB, R_F=0; the following cycle R_T=0 and D_T holds 0x00AB.
- Skewed arrival: data tokens 0x0001, 0x0002, 0x0003 on cycles 0–2, then conditions 0, 1, 0 on cycles 5–7 → R_F/D_F=0x0001, R_T/D_T=0x0002, R_F/D_F=0x0003 on edges 5, 6, 7 (one cycle after each condition is presented); OVF=0.
- Overflow: DEPTH=4, five condition tokens with no data → fifth token dropped, OVF=1. Then four data tokens → exactly four outputs; OVF stays 1.
- Full with simultaneous pop and push: CQ full (4 entries); present data plus a new condition in the same cycle → one output fires, the new condition is accepted, OVF=0, occupancy stays 4.
- EN gating: EN=0 with R_COND=1 and R_IN=1 for 3 cycles → no outputs, FIFOs unchanged. Set EN=1 with no input → no outputs, confirming the gated tokens were discarded.
- Async reset mid-stream: 2 conditions buffered, R_T pulsing; assert RST between edges → all outputs 0 immediately. After deassert, one data token → no output, since the buffered conditions were lost.
